// File: rtl/byte_serializer.sv
// Parallel-to-serial word transmitter with a one-entry hold buffer behind the shifter.
// Drives serial_out qualified by shift_enable, gap-free across back-to-back words.
module byte_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              shift_enable,
    output logic              byte_sent,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] BitLast = CntW'(DATA_W - 1);
    localparam logic [3:0] GapLast = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shifter_q, shifter_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              byte_sent_q, byte_sent_d;

    logic              transfer;
    logic              last_bit;
    logic              load_slot;
    logic [DATA_W-1:0] shifted;

    assign in_ready     = ~hold_full_q & ~rst;
    assign shift_enable = (state_q == StShift);
    assign serial_out   = shift_enable &
                          ((MSB_FIRST != 0) ? shifter_q[DATA_W-1] : shifter_q[0]);
    assign byte_sent    = byte_sent_q;
    assign busy         = (state_q != StIdle) | hold_full_q;

    always_comb begin
        transfer  = in_valid & in_ready;
        last_bit  = (state_q == StShift) && (bit_cnt_q == BitLast);
        load_slot = (state_q == StIdle) || (last_bit && (IDLE_GAP == 0)) ||
                    ((state_q == StGap) && (gap_cnt_q == GapLast));
        if (MSB_FIRST != 0) begin
            shifted = {shifter_q[DATA_W-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shifter_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        byte_sent_d = 1'b0;

        case (state_q)
            StShift: begin
                shifter_d = shifted;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (last_bit) begin
                    byte_sent_d = 1'b1;
                    bit_cnt_d   = '0;
                    gap_cnt_d   = '0;
                    state_d     = (IDLE_GAP > 0) ? StGap : StIdle;
                end
            end
            StGap:   gap_cnt_d = gap_cnt_q + 1'b1;
            default: ;
        endcase

        // The hold word always goes first so ordering is preserved; a fresh word
        // bypasses straight into the shifter only when nothing is waiting.
        if (load_slot) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
                shifter_d   = hold_q;
                state_d     = StShift;
                hold_full_d = transfer;
                if (transfer) begin
                    hold_d = in_data;
                end
            end else if (transfer) begin
                shifter_d = in_data;
                state_d   = StShift;
            end else begin
                state_d = StIdle;
            end
        end else if (transfer) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shifter_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            byte_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            byte_sent_q <= byte_sent_d;
        end
    end

endmodule
